// File: rtl/qos_pkg.sv
// -----------------------------------------------------------------------------
// qos_pkg
// Shared definitions for the QoS PCIe write-side distributor.
//   NUM_FIFOS / CLASS_W : number of class FIFOs and width of the class field
//   class_lsb()         : bit position of the class field inside a word
//   class_onehot()      : class number to one-hot push strobe
//   state_t             : distributor FSM states
// -----------------------------------------------------------------------------
package qos_pkg;

   localparam int NUM_FIFOS = 4;
   localparam int CLASS_W   = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS  = 2'd1,
      STALL = 2'd2
   } state_t;

   // The class field occupies the top CLASS_W bits of a word.
   function automatic int class_lsb(input int data_width);
      return data_width - CLASS_W;
   endfunction

   function automatic logic [NUM_FIFOS-1:0] class_onehot(input logic [CLASS_W-1:0] cls);
      return NUM_FIFOS'(1) << cls;
   endfunction

endpackage

// File: rtl/push_counter.sv
// -----------------------------------------------------------------------------
// push_counter
// Free-running wrap-around counter of pushes into one class FIFO.
//   clk     : clock
//   reset_L : asynchronous active-low reset, clears the count
//   inc_en  : add one this cycle
//   count   : current count (wraps modulo 2^CNT_WIDTH)
// -----------------------------------------------------------------------------
module push_counter #(
   parameter int CNT_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 reset_L,
   input  logic                 inc_en,
   output logic [CNT_WIDTH-1:0] count
);

   logic [CNT_WIDTH-1:0] count_reg;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         count_reg <= '0;
      end else if (inc_en) begin
         count_reg <= count_reg + CNT_WIDTH'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/demux_class_push.sv
// -----------------------------------------------------------------------------
// demux_class_push
// Decodes the traffic class of each incoming word and pushes it into one of
// four class FIFOs, holding a single word while its target FIFO is almost full.
//   clk         : clock
//   reset_L     : asynchronous active-low reset
//   data_in     : incoming word, class in the top two bits
//   valid_in    : data_in is valid
//   ready_out   : a word can be accepted this cycle
//   almost_full : almost-full flag of FIFO 0..3
//   demux_out   : registered word presented to the FIFOs (0 when no push)
//   push        : registered one-hot push strobe to FIFO 0..3
//   count_out   : packed per-class push counters, class k at [k*CNT_WIDTH +: CNT_WIDTH]
//   idle_out    : FSM is in IDLE
// -----------------------------------------------------------------------------
module demux_class_push
   import qos_pkg::*;
#(
   parameter int DATA_WIDTH = 12,
   parameter int CNT_WIDTH  = 5
) (
   input  logic                           clk,
   input  logic                           reset_L,
   input  logic [DATA_WIDTH-1:0]          data_in,
   input  logic                           valid_in,
   output logic                           ready_out,
   input  logic [NUM_FIFOS-1:0]           almost_full,
   output logic [DATA_WIDTH-1:0]          demux_out,
   output logic [NUM_FIFOS-1:0]           push,
   output logic [NUM_FIFOS*CNT_WIDTH-1:0] count_out,
   output logic                           idle_out
);

   localparam int CLASS_LSB = class_lsb(DATA_WIDTH);

   state_t                  state_reg;
   logic [NUM_FIFOS-1:0]    push_reg;
   logic [DATA_WIDTH-1:0]   demux_reg;
   logic [DATA_WIDTH-1:0]   held_data_reg;
   logic [CLASS_W-1:0]      held_class_reg;
   logic [CLASS_W-1:0]      in_class;

   assign in_class = data_in[CLASS_LSB +: CLASS_W];

   // Accept decision uses only the registered state, so ready_out has no
   // combinational dependency on valid_in or almost_full.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_reg      <= IDLE;
         push_reg       <= '0;
         demux_reg      <= '0;
         held_data_reg  <= '0;
         held_class_reg <= '0;
      end else begin
         unique case (state_reg)
            IDLE, PASS: begin
               if (valid_in && !almost_full[in_class]) begin
                  state_reg <= PASS;
                  push_reg  <= class_onehot(in_class);
                  demux_reg <= data_in;
               end else if (valid_in) begin
                  state_reg      <= STALL;
                  push_reg       <= '0;
                  demux_reg      <= '0;
                  held_data_reg  <= data_in;
                  held_class_reg <= in_class;
               end else begin
                  state_reg <= IDLE;
                  push_reg  <= '0;
                  demux_reg <= '0;
               end
            end
            STALL: begin
               // Only the held class matters: head-of-line blocking is intended.
               if (!almost_full[held_class_reg]) begin
                  state_reg <= PASS;
                  push_reg  <= class_onehot(held_class_reg);
                  demux_reg <= held_data_reg;
               end else begin
                  push_reg  <= '0;
                  demux_reg <= '0;
               end
            end
            default: begin
               state_reg <= IDLE;
               push_reg  <= '0;
               demux_reg <= '0;
            end
         endcase
      end
   end

   assign ready_out = (state_reg != STALL);
   assign idle_out  = (state_reg == IDLE);
   assign push      = push_reg;
   assign demux_out = demux_reg;

   // Counters follow the registered strobe, so a count lands one cycle after its push.
   generate
      for (genvar gi = 0; gi < NUM_FIFOS; gi++) begin : g_cnt
         push_counter #(
            .CNT_WIDTH (CNT_WIDTH)
         ) u_push_counter (
            .clk     (clk),
            .reset_L (reset_L),
            .inc_en  (push_reg[gi]),
            .count   (count_out[gi*CNT_WIDTH +: CNT_WIDTH])
         );
      end
   endgenerate

endmodule

// File: tb/tb_demux_class_push.sv
// -----------------------------------------------------------------------------
// tb_demux_class_push
// Directed stimulus; expected pushes go to a scoreboard queue that a negedge
// monitor drains whenever the DUT strobes push.
// -----------------------------------------------------------------------------
module tb_demux_class_push;

   logic        clk = 1'b0;
   logic        reset_L;
   logic [11:0] data_in;
   logic        valid_in;
   logic        ready_out;
   logic [3:0]  almost_full;
   logic [11:0] demux_out;
   logic [3:0]  push;
   logic [19:0] count_out;
   logic        idle_out;

   typedef struct packed {
      logic [3:0]  push;
      logic [11:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   demux_class_push #(
      .DATA_WIDTH (12),
      .CNT_WIDTH  (5)
   ) dut (
      .clk         (clk),
      .reset_L     (reset_L),
      .data_in     (data_in),
      .valid_in    (valid_in),
      .ready_out   (ready_out),
      .almost_full (almost_full),
      .demux_out   (demux_out),
      .push        (push),
      .count_out   (count_out),
      .idle_out    (idle_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_push(input logic [3:0] p, input logic [11:0] d);
      exp_t e;
      e.push = p;
      e.data = d;
      sb.push_back(e);
   endtask

   function automatic logic [19:0] counts(input int c3, input int c2, input int c1, input int c0);
      return {5'(c3), 5'(c2), 5'(c1), 5'(c0)};
   endfunction

   // Monitor: every push is matched against the scoreboard; demux_out must be 0 otherwise.
   always @(negedge clk) begin
      if (reset_L === 1'b1) begin
         if (push !== 4'b0) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_push actual push=%b data=%h required no push", push, demux_out);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (push !== e.push || demux_out !== e.data) begin
                  errors++;
                  $display("FAIL push_word actual push=%b data=%h required push=%b data=%h",
                           push, demux_out, e.push, e.data);
               end else begin
                  $display("ok   push_word push=%b data=%h", push, demux_out);
               end
            end
         end else begin
            checks++;
            if (demux_out !== 12'h000) begin
               errors++;
               $display("FAIL demux_zero actual=%h required=000", demux_out);
            end
         end
      end
   end

   initial begin
      logic [11:0] words [4];
      words[0] = 12'h005; words[1] = 12'h405; words[2] = 12'h805; words[3] = 12'hC05;

      reset_L = 1'b0; valid_in = 1'b0; data_in = '0; almost_full = '0;
      repeat (3) tick();
      check("rst_push", 32'(push), 32'h0);
      check("rst_demux", 32'(demux_out), 32'h0);
      check("rst_count", 32'(count_out), 32'h0);
      check("rst_ready", 32'(ready_out), 32'h1);
      check("rst_idle", 32'(idle_out), 32'h1);
      reset_L = 1'b1;
      tick();

      // Back-to-back one word per class.
      for (int i = 0; i < 4; i++) begin
         valid_in = 1'b1;
         data_in  = words[i];
         expect_push(4'(1 << i), words[i]);
         tick();
      end
      valid_in = 1'b0;
      tick();
      check("count_after_4", 32'(count_out), 32'(counts(1, 1, 1, 1)));

      // Stall on class 2.
      almost_full = 4'b0100;
      valid_in = 1'b1; data_in = 12'h8AA;
      tick();
      check("stall_ready", 32'(ready_out), 32'h0);
      check("stall_push", 32'(push), 32'h0);
      check("stall_idle", 32'(idle_out), 32'h0);
      // Other-class almost_full changes and a new word are ignored while stalled.
      almost_full = 4'b0101; data_in = 12'h011;
      tick();
      check("stall_hol_ready", 32'(ready_out), 32'h0);
      check("stall_hol_push", 32'(push), 32'h0);
      almost_full = 4'b0100;
      tick();
      check("stall_hol2_push", 32'(push), 32'h0);
      almost_full = 4'b0000;
      expect_push(4'b0100, 12'h8AA);
      tick();
      check("release_push", 32'(push), 32'h4);
      check("release_data", 32'(demux_out), 32'h8AA);
      check("release_ready", 32'(ready_out), 32'h1);
      expect_push(4'b0001, 12'h011);
      tick();
      valid_in = 1'b0;
      tick();
      tick();
      check("count_after_stall", 32'(count_out), 32'(counts(1, 2, 1, 2)));

      // Class-3 counter wraps: 1 + 31 = 32 -> 0.
      for (int i = 0; i < 31; i++) begin
         valid_in = 1'b1;
         data_in  = 12'hC00 + 12'(i);
         expect_push(4'b1000, 12'hC00 + 12'(i));
         tick();
      end
      valid_in = 1'b0;
      tick();
      tick();
      check("count_wrap", 32'(count_out), 32'(counts(0, 2, 1, 2)));
      valid_in = 1'b1; data_in = 12'hFFF;
      expect_push(4'b1000, 12'hFFF);
      tick();
      valid_in = 1'b0;
      tick();
      tick();
      check("count_post_wrap", 32'(count_out), 32'(counts(1, 2, 1, 2)));

      // Asynchronous reset while holding 12'hC3C.
      almost_full = 4'b1000;
      valid_in = 1'b1; data_in = 12'hC3C;
      tick();
      valid_in = 1'b0;
      check("c3c_stall_ready", 32'(ready_out), 32'h0);
      #2;
      reset_L = 1'b0;
      #1;
      check("async_push", 32'(push), 32'h0);
      check("async_demux", 32'(demux_out), 32'h0);
      check("async_count", 32'(count_out), 32'h0);
      check("async_ready", 32'(ready_out), 32'h1);
      check("async_idle", 32'(idle_out), 32'h1);
      almost_full = 4'b0000;
      tick();
      reset_L = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_reset_no_push", 32'(push), 32'h0);
      end

      // Idle stream.
      for (int i = 0; i < 6; i++) begin
         tick();
         check("idle_push", 32'(push), 32'h0);
         check("idle_demux", 32'(demux_out), 32'h0);
         check("idle_flag", 32'(idle_out), 32'h1);
      end

      // Bounded drain of the scoreboard.
      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      check("scoreboard_empty", 32'(sb.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/demux_class_push.md
# demux_class_push

Write-side distributor of the QoS PCIe path: accepts a 12-bit word stream, decodes the traffic class from the word, and pushes the word into one of four class FIFOs. It is the push-side counterpart of the priority pop mux that drains those FIFOs. It honours per-FIFO almost-full backpressure with a one-word holding register and keeps per-class push counters for the checker.

## Interface
Parameters:
- DATA_WIDTH, 12, word width; class field is bits [DATA_WIDTH-1:DATA_WIDTH-2].
- CNT_WIDTH, 5, width of each per-class push counter.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- data_in  in  DATA_WIDTH  incoming word.
- valid_in  in  1  data_in is valid this cycle.
- ready_out  out  1  block can accept a word this cycle.
- almost_full  in  4  almost-full flag of FIFO 0..3.
- demux_out  out  DATA_WIDTH  word presented to the FIFOs (registered).
- push  out  4  one-hot push strobe to FIFO 0..3 (registered).
- count_out  out  4*CNT_WIDTH  packed push counters; class k at [k*CNT_WIDTH +: CNT_WIDTH].
- idle_out  out  1  high when the FSM is in IDLE.

## Operation
- Class c = data_in[DATA_WIDTH-1:DATA_WIDTH-2].
- Accept: valid_in && ready_out at a rising edge.
- FSM states: IDLE (no push this cycle), PASS (push asserted this cycle), STALL (word held, waiting).
- From IDLE or PASS:
  - accept and almost_full[c]==0 -> PASS; push[c]=1, demux_out=data_in.
  - accept and almost_full[c]==1 -> STALL; word and class go to the holding register.
  - otherwise -> IDLE.
- From STALL:
  - almost_full[held class]==0 -> PASS; push the held word.
  - otherwise -> stay in STALL.
- ready_out = (state != STALL). It is decoded from state only, with no combinational path from valid_in or almost_full.
- When push==0, demux_out=0 and the holding register retains its contents.
- push is always one-hot or zero; never more than one bit.
- count_out[k] increments by 1 on every cycle where push[k]=1 and wraps modulo 2^CNT_WIDTH.
- Reset values: state IDLE, push=0, demux_out=0, count_out=0, holding register=0, ready_out=1, idle_out=1.
- Reset asserted mid-operation discards the held word; no push is issued for it after reset release.

## Timing
- Latency: data_in to push/demux_out is 1 cycle when not stalled.
- Throughput: 1 word/cycle while the target FIFOs are not almost-full.
- almost_full is sampled at the accepting edge; a later assertion does not cancel an already-registered push.
- Stall release: the push occurs on the edge after almost_full[held] is seen low. ready_out returns high in the same cycle push is asserted, so a new word may be accepted on that edge. This costs exactly one bubble per stall.
- valid_in while ready_out=0 is ignored; the source must hold data_in until accepted.
- almost_full changes on non-held classes during STALL have no effect (head-of-line blocking is intended).

## Structure
- Shared package (qos_pkg), holding:
  - NUM_FIFOS=4 and CLASS_W=2;
  - the class-field position function;
  - the FSM state enum: IDLE=2'd0, PASS=2'd1, STALL=2'd2.
- Sub-module push_counter (CNT_WIDTH counter with increment enable, async active-low reset), instantiated four times.
- The FSM, the holding register and the output registers live in the top level.

## Test plan
- Reset, then words 12'h005 (class 0), 12'h405 (class 1), 12'h805 (class 2), 12'hC05 (class 3) back-to-back with almost_full=0:
  - push is 0001, 0010, 0100, 1000 on cycles 1-4;
  - demux_out echoes each word;
  - each counter = 1.
- almost_full=4'b0100, send 12'h8AA:
  - ready_out drops next cycle and push stays 0;
  - after almost_full is cleared, push=0100 and demux_out=12'h8AA one cycle later;
  - ready_out=1 in that same cycle.
- During STALL on class 2:
  - toggle almost_full[0] and drive valid_in with 12'h011: no push occurs and the word is not accepted;
  - after release, 12'h011 is accepted only once ready_out=1.
- 32 class-3 pushes: count_out[3] wraps to 0 and the other counters are unchanged.
- reset_L pulsed low during STALL holding 12'hC3C:
  - all outputs go to reset values immediately (asynchronously);
  - no push of 12'hC3C after release.
- Idle stream (valid_in=0): push=0, demux_out=0, idle_out=1 every cycle.
